// File: rtl/dflipflop.sv
// rtl/dflipflop.sv - positive-edge D flip-flop with asynchronous active-high reset
//
// Purpose: basic WIDTH-bit storage element. Captures in on each rising edge of
// clk and holds it on out until the next rising edge. Registers, counters and
// memory cells are built on this cell.
//
// Parameters:
//   WIDTH        data width in bits (default 1, the canonical single-bit cell)
//   RESET_VALUE  value forced onto the stored state while reset is high
//
// Ports (positional order in, clk, out, reset; reset is last so existing
// callers that connect (in, clk, out) positionally keep working):
//   in     input  [WIDTH-1:0]  data sampled at the rising edge of clk
//   clk    input               clock; only rising edges update state
//   out    output [WIDTH-1:0]  stored state, no combinational path from in
//   reset  input               asynchronous active-high reset; tie low when unused
module dflipflop #(
   parameter int unsigned           WIDTH       = 1,
   parameter logic [WIDTH-1:0]      RESET_VALUE = '0
) (
   input  logic [WIDTH-1:0] in,
   input  logic             clk,
   output logic [WIDTH-1:0] out,
   input  logic             reset
);

   // Reset is in the sensitivity list so it acts without a clock edge and wins
   // over a simultaneous rising edge of clk. All bits share one process, so the
   // whole word is captured on the same edge.
   always_ff @(posedge clk or posedge reset) begin
      if (reset) begin
         out <= RESET_VALUE;
      end else begin
         out <= in;
      end
   end

endmodule

// File: tb/tb_dflipflop.sv
// tb/tb_dflipflop.sv - directed self-checking bench for dflipflop
module tb_dflipflop;

   logic       clk1   = 1'b0;
   logic       reset1 = 1'b0;
   logic       in1    = 1'b0;
   logic       out1;

   logic       clk8   = 1'b0;
   logic       reset8 = 1'b0;
   logic [7:0] in8    = 8'h00;
   logic [7:0] out8;

   int checks = 0;
   int errors = 0;

   dflipflop u_dff1 (
      .in    (in1),
      .clk   (clk1),
      .out   (out1),
      .reset (reset1)
   );

   dflipflop #(
      .WIDTH       (8),
      .RESET_VALUE (8'hA5)
   ) u_dff8 (
      .in    (in8),
      .clk   (clk8),
      .out   (out8),
      .reset (reset8)
   );

   task automatic check(input string tag, input logic [7:0] got, input logic [7:0] exp);
      checks++;
      if (got !== exp) begin
         errors++;
         $display("FAIL %s got=%h exp=%h", tag, got, exp);
      end
   endtask

   initial begin
      // Reset behaviour on the 1-bit cell
      clk1 = 1'b0; in1 = 1'b1;
      #5 reset1 = 1'b1;
      #1 check("rst_async", {7'b0, out1}, 8'h00);
      #4 clk1 = 1'b1;
      #1 check("rst_dominates_clk", {7'b0, out1}, 8'h00);
      #4 clk1 = 1'b0;
      #5 reset1 = 1'b0;
      #1 check("rst_release_hold", {7'b0, out1}, 8'h00);
      #4 clk1 = 1'b1;
      #1 check("rst_release_capture", {7'b0, out1}, 8'h01);

      // Basic capture and no transparency while clk is low
      #4 clk1 = 1'b0; in1 = 1'b0;
      #5 clk1 = 1'b1;
      #1 check("capture_zero", {7'b0, out1}, 8'h00);
      #4 clk1 = 1'b0; in1 = 1'b1;
      #5 check("low_no_transparency", {7'b0, out1}, 8'h00);

      // Load one, then hold against in change
      clk1 = 1'b1;
      #1 check("load_one", {7'b0, out1}, 8'h01);
      #4 clk1 = 1'b0; in1 = 1'b0;
      #5 check("hold_one", {7'b0, out1}, 8'h01);

      // Load zero, toggle in while clk high, falling edge with in=1
      clk1 = 1'b1;
      #1 check("load_zero", {7'b0, out1}, 8'h00);
      #2 in1 = 1'b1;
      #1 check("high_hold_a", {7'b0, out1}, 8'h00);
      #2 in1 = 1'b0;
      #1 check("high_hold_b", {7'b0, out1}, 8'h00);
      in1 = 1'b1;
      #1 clk1 = 1'b0;
      #1 check("falling_no_effect", {7'b0, out1}, 8'h00);

      // Async reset in the middle of a hold period
      #3 clk1 = 1'b1;
      #1 check("preload_one", {7'b0, out1}, 8'h01);
      #4 clk1 = 1'b0;
      #5 reset1 = 1'b1;
      #1 check("rst_mid_hold", {7'b0, out1}, 8'h00);
      #4 reset1 = 1'b0;
      #5 check("rst_mid_release_hold", {7'b0, out1}, 8'h00);
      clk1 = 1'b1;
      #1 check("rst_mid_recapture", {7'b0, out1}, 8'h01);

      // Pre-edge value captured when in changes by NBA at the edge
      #4 clk1 = 1'b0; in1 = 1'b0;
      #5 clk1 = 1'b1;
      #1 check("pre_race_zero", {7'b0, out1}, 8'h00);
      #4 clk1 = 1'b0; in1 = 1'b1;
      #5;
      in1 <= 1'b0;
      clk1 = 1'b1;
      #1 check("nba_race_pre_edge", {7'b0, out1}, 8'h01);
      #4 clk1 = 1'b0;

      // 8-bit cell with non-zero reset value
      #5 reset8 = 1'b1;
      #1 check("w8_reset_value", out8, 8'hA5);
      #4 reset8 = 1'b0; in8 = 8'h3C;
      #5 clk8 = 1'b1;
      #1 check("w8_capture", out8, 8'h3C);
      #4 clk8 = 1'b0; in8 = 8'hFF;
      #5 check("w8_hold", out8, 8'h3C);
      clk8 = 1'b1;
      #1 check("w8_capture_ff", out8, 8'hFF);
      #4 clk8 = 1'b0; in8 = 8'h5A;
      #5 reset8 = 1'b1;
      #1 check("w8_async_reset", out8, 8'hA5);
      #4 reset8 = 1'b0;
      #5 clk8 = 1'b1;
      #1 check("w8_after_reset", out8, 8'h5A);

      #5;
      $display("CHECKS %0d ERRORS %0d", checks, errors);
      $finish;
   end

endmodule
